// File: rtl/bnn_pkg.sv
// Shared types and constant helpers for the binary convolution datapath.
// Pure declarations: no latency, no backpressure.
package bnn_pkg;

   typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

   // Majority threshold: a filter fires when at least half the bits agree.
   function automatic int default_th(input int n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/bnn_conv_xnor_pe_if.sv
// Window/feature valid-ready channel plus weight/threshold write port of the XNOR conv engine.
// Wiring only: latency and backpressure are defined by the engine on the slave side.
interface bnn_conv_xnor_pe_if #(
   parameter int N      = 9,
   parameter int OUT_CH = 8,
   parameter int AW     = 4,
   parameter int PCW    = 4
);
   logic              valid_in;
   logic              in_ready;
   logic [N-1:0]      window;
   logic              valid_out;
   logic              ready_out;
   logic [OUT_CH-1:0] feat_out;
   logic              w_wr_en;
   logic [AW-1:0]     w_wr_addr;
   logic [N-1:0]      w_wr_data;
   logic [PCW-1:0]    th_wr_data;
   logic              w_wr_err;

   modport master (
      output valid_in, window, ready_out, w_wr_en, w_wr_addr, w_wr_data, th_wr_data,
      input  in_ready, valid_out, feat_out, w_wr_err
   );

   modport slave (
      input  valid_in, window, ready_out, w_wr_en, w_wr_addr, w_wr_data, th_wr_data,
      output in_ready, valid_out, feat_out, w_wr_err
   );
endinterface

// File: rtl/bnn_xnor_popcnt.sv
// One filter lane: XNOR window against weights, popcount, compare with threshold.
// Combinational (0 cycles), no flow control.
module bnn_xnor_popcnt #(
   parameter int N   = 9,
   parameter int PCW = 4
) (
   input  logic [N-1:0]   window,
   input  logic [N-1:0]   weight,
   input  logic [PCW-1:0] th,
   output logic           hit
);
   logic [N-1:0]   match;
   logic [PCW-1:0] cnt;

   always_comb begin
      match = ~(window ^ weight);
      cnt   = '0;
      for (int i = 0; i < N; i++)
         cnt = cnt + PCW'(match[i]);
      hit = (cnt >= th);
   end
endmodule

// File: rtl/bnn_conv_xnor_pe.sv
// Binary conv engine: OUT_CH XNOR-popcount filters, LANES per cycle, valid_out NPASS cycles after capture.
// Result held on valid_out until ready_out; in_ready low while computing; weight writes only accepted when idle.
module bnn_conv_xnor_pe
   import bnn_pkg::*;
#(
   parameter int KSIZE  = 3,
   parameter int IN_CH  = 1,
   parameter int OUT_CH = 8,
   parameter int LANES  = 2
) (
   input logic              clk,
   input logic              rst_n,
   bnn_conv_xnor_pe_if.slave bus
);
   localparam int N     = KSIZE * KSIZE * IN_CH;
   localparam int NPASS = OUT_CH / LANES;
   localparam int PCW   = clog2(N + 1);
   localparam int FW    = (OUT_CH > 1) ? clog2(OUT_CH) : 1;
   localparam int PW    = (NPASS > 1) ? clog2(NPASS) : 1;
   // One spare address code so out-of-range filter indices can be seen and rejected.
   localparam int AW    = clog2(OUT_CH + 1);
   localparam logic [PCW-1:0] TH_DEF = PCW'(default_th(N));

   state_t            state, state_nxt;
   logic [PW-1:0]     pass_cnt;
   logic [N-1:0]      win_q;
   logic [OUT_CH-1:0] result;
   logic [N-1:0]      w_mem  [OUT_CH];
   logic [PCW-1:0]    th_mem [OUT_CH];
   logic [FW-1:0]     lane_idx [LANES];
   logic [LANES-1:0]  lane_hit;
   logic              in_rdy;
   logic              capture;
   logic              last_pass;
   logic              wr_ok;

   assign last_pass = (pass_cnt == PW'(NPASS - 1));
   assign capture   = bus.valid_in && in_rdy;
   assign wr_ok     = bus.w_wr_en && (state == IDLE) && (bus.w_wr_addr < AW'(OUT_CH));
   assign bus.in_ready = in_rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.valid_in) state_nxt = CALC;
         CALC:    if (last_pass) state_nxt = HOLD;
         HOLD:    if (bus.ready_out) state_nxt = bus.valid_in ? CALC : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Result bits only reach feat_out in HOLD so partial passes never leak.
   always_comb begin
      in_rdy        = 1'b0;
      bus.valid_out = 1'b0;
      bus.feat_out  = '0;
      case (state)
         IDLE: in_rdy = 1'b1;
         HOLD: begin
            in_rdy        = bus.ready_out;
            bus.valid_out = 1'b1;
            bus.feat_out  = result;
         end
         default: ;
      endcase
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = FW'(pass_cnt) * FW'(LANES) + FW'(l);
      bnn_xnor_popcnt #(.N(N), .PCW(PCW)) u_lane (
         .window (win_q),
         .weight (w_mem[lane_idx[l]]),
         .th     (th_mem[lane_idx[l]]),
         .hit    (lane_hit[l])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q    <= '0;
         result   <= '0;
         pass_cnt <= '0;
      end else begin
         if (capture) win_q <= bus.window;
         if (state == CALC) begin
            for (int l = 0; l < LANES; l++)
               result[lane_idx[l]] <= lane_hit[l];
            pass_cnt <= last_pass ? '0 : pass_cnt + PW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < OUT_CH; c++) begin
            w_mem[c]  <= '0;
            th_mem[c] <= TH_DEF;
         end
         bus.w_wr_err <= 1'b0;
      end else begin
         if (wr_ok) begin
            w_mem[bus.w_wr_addr[FW-1:0]]  <= bus.w_wr_data;
            th_mem[bus.w_wr_addr[FW-1:0]] <= bus.th_wr_data;
         end
         bus.w_wr_err <= bus.w_wr_en && !wr_ok;
      end
   end
endmodule

// File: tb/tb_bnn_conv_xnor_pe.sv
// Scoreboarded bench: random windows/weights against a popcount model; second instance runs single-pass config.
module tb_bnn_conv_xnor_pe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   bnn_conv_xnor_pe_if #(.N(9), .OUT_CH(8), .AW(4), .PCW(4)) bus ();
   bnn_conv_xnor_pe_if #(.N(9), .OUT_CH(8), .AW(4), .PCW(4)) bus8 ();

   bnn_conv_xnor_pe #(.KSIZE(3), .IN_CH(1), .OUT_CH(8), .LANES(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus));
   bnn_conv_xnor_pe #(.KSIZE(3), .IN_CH(1), .OUT_CH(8), .LANES(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .bus(bus8));

   typedef struct {
      logic [7:0] feat;
      int         cap;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         failures = 0;
   int         cyc = 0;
   int         rdy_mode = 0;
   logic [8:0] w_m  [8];
   logic [3:0] th_m [8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model(input logic [8:0] win, input logic [8:0] w[8],
                                        input logic [3:0] th[8]);
      logic [7:0] r;
      r = '0;
      for (int c = 0; c < 8; c++)
         r[c] = ($countones(~(win ^ w[c])) >= int'(th[c]));
      return r;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 8; c++) begin
         w_m[c]  = '0;
         th_m[c] = 4'd5;
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       bus.ready_out = 1'b1;
         1:       bus.ready_out = 1'($urandom_range(0, 1));
         default: bus.ready_out = 1'b0;
      endcase
   end

   // Monitor: feat compared against queue head every cycle it is presented (covers stall stability).
   bit prev_vld = 1'b0;
   bit popped = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_vld = 1'b0;
         popped   = 1'b0;
      end else begin
         if (bus.valid_out) begin
            if (q.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               check("feat_out", bus.feat_out, q[0].feat);
               if (!prev_vld || popped) check("latency", cyc - q[0].cap, 4);
               popped = 1'b0;
               if (bus.ready_out) begin
                  void'(q.pop_front());
                  popped = 1'b1;
               end
            end
            check("in_ready_hold", bus.in_ready, bus.ready_out);
         end else begin
            popped = 1'b0;
            check("in_ready", bus.in_ready, (q.size() == 0) ? 1 : 0);
         end
         prev_vld = bus.valid_out;
      end
   end

   task automatic send(input logic [8:0] win);
      logic [7:0] e;
      int n;
      n = 0;
      @(posedge clk); #1;
      bus.valid_in = 1'b1;
      bus.window   = win;
      e = model(win, w_m, th_m);
      forever begin
         @(negedge clk);
         if (bus.in_ready) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk); #1;
      bus.valid_in = 1'b0;
      q.push_back('{feat: e, cap: cyc});
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      forever begin
         @(negedge clk);
         if (q.size() == 0 && !bus.valid_out) break;
         n++;
         if (n > 500) begin
            check("idle_timeout", 1, 0);
            break;
         end
      end
   endtask

   task automatic wr(input int addr, input logic [8:0] w, input logic [3:0] th, input bit exp_err);
      @(posedge clk); #1;
      bus.w_wr_en    = 1'b1;
      bus.w_wr_addr  = 4'(addr);
      bus.w_wr_data  = w;
      bus.th_wr_data = th;
      @(posedge clk); #1;
      bus.w_wr_en = 1'b0;
      check("wr_err", bus.w_wr_err, exp_err);
      if (!exp_err) begin
         w_m[addr]  = w;
         th_m[addr] = th;
      end
      @(posedge clk); #1;
      check("wr_err_pulse", bus.w_wr_err, 0);
   endtask

   initial begin
      logic [8:0] w8  [8];
      logic [3:0] th8 [8];
      logic [8:0] win;
      int a;
      int n;

      bus.valid_in = 1'b0; bus.window = '0; bus.ready_out = 1'b1;
      bus.w_wr_en = 1'b0; bus.w_wr_addr = '0; bus.w_wr_data = '0; bus.th_wr_data = '0;
      bus8.valid_in = 1'b0; bus8.window = '0; bus8.ready_out = 1'b1;
      bus8.w_wr_en = 1'b0; bus8.w_wr_addr = '0; bus8.w_wr_data = '0; bus8.th_wr_data = '0;
      model_reset();

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_out", bus.valid_out, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_feat_out", bus.feat_out, 0);
      check("rst_wr_err", bus.w_wr_err, 0);
      check("rst8_in_ready", bus8.in_ready, 1);
      rst_n = 1'b1;

      // Default weights: all-ones window gives zero matches.
      send(9'h1FF);
      wait_idle();

      for (int c = 0; c < 8; c++) wr(c, 9'h1FF, 4'd5, 1'b0);
      send(9'h01F);
      send(9'h00F);
      wait_idle();

      for (int c = 0; c < 8; c++) wr(c, 9'h000, 4'(c), 1'b0);
      send(9'h000);
      wait_idle();
      wr(3, 9'h000, 4'd10, 1'b0);
      send(9'h000);
      wait_idle();

      // Stall in HOLD, then release with a back-to-back window.
      rdy_mode = 2;
      send(9'($urandom));
      n = 0;
      while (!bus.valid_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("hold_reached", bus.valid_out, 1);
      repeat (6) @(posedge clk);
      rdy_mode = 0;
      send(9'($urandom));
      wait_idle();

      // Dropped writes: during CALC and to an out-of-range filter.
      send(9'($urandom));
      wr(2, 9'($urandom), 4'($urandom_range(0, 11)), 1'b1);
      wait_idle();
      wr(8, 9'($urandom), 4'($urandom_range(0, 11)), 1'b1);
      send(9'($urandom));
      wait_idle();

      rdy_mode = 1;
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 3) == 0) begin
            wait_idle();
            a = $urandom_range(0, 9);
            wr(a, 9'($urandom), 4'($urandom_range(0, 11)), a >= 8);
         end
         send(9'($urandom));
      end
      rdy_mode = 0;
      wait_idle();

      // Reset in the middle of a computation.
      send(9'($urandom));
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid_out", bus.valid_out, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_feat_out", bus.feat_out, 0);
      q.delete();
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(9'($urandom));
      send(9'h1F0);
      wait_idle();

      // Single-pass configuration.
      for (int c = 0; c < 8; c++) begin
         w8[c]  = 9'($urandom);
         th8[c] = 4'($urandom_range(0, 10));
         @(posedge clk); #1;
         bus8.w_wr_en = 1'b1; bus8.w_wr_addr = 4'(c);
         bus8.w_wr_data = w8[c]; bus8.th_wr_data = th8[c];
      end
      @(posedge clk); #1;
      bus8.w_wr_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         win = 9'($urandom);
         @(posedge clk); #1;
         bus8.valid_in = 1'b1;
         bus8.window   = win;
         @(negedge clk);
         check("l8_in_ready", bus8.in_ready, 1);
         @(posedge clk); #1;
         bus8.valid_in = 1'b0;
         check("l8_calc_valid", bus8.valid_out, 0);
         @(posedge clk); #1;
         check("l8_valid_out", bus8.valid_out, 1);
         check("l8_feat_out", bus8.feat_out, model(win, w8, th8));
      end
      @(posedge clk); #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
